// File: rtl/sudoku_ps2_cmd.sv
// PS/2 keyboard receiver and scancode decoder driving the Sudoku engine command port.
// Build option: define PS2_TYPEMATIC_EN to emit auto-repeat makes of the held key.
module sudoku_ps2_cmd #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] cmd_number,
  output logic       cmd_up,
  output logic       cmd_down,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic       cmd_enter,
  output logic       cmd_valid,
  output logic       frame_error
);

  localparam logic       RX_IDLE  = 1'b0;
  localparam logic       RX_SHIFT = 1'b1;
  localparam logic [1:0] DEC_BASE = 2'd0;
  localparam logic [1:0] DEC_E0   = 2'd1;
  localparam logic [1:0] DEC_F0   = 2'd2;
  localparam logic [1:0] DEC_E0F0 = 2'd3;

  localparam int unsigned WD_NEED = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WD_W    = (WD_NEED > 17) ? WD_NEED : 17;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s, w_dat_s, w_fall;

  logic            r_rx_state;
  logic [3:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic [WD_W-1:0] r_wd;
  logic [7:0]      r_byte;
  logic            r_byte_vld;
  logic            r_rx_err;

  logic [1:0] r_dec_state;
  logic [7:0] r_held_code;
  logic       r_held_ext;
  logic       r_held_vld;

  logic       w_ext, w_brk, w_e0_step, w_f0_step, w_final;
  logic       w_mapped, w_make, w_emit, w_held_match;
  logic [3:0] w_num;
  logic       w_up, w_down, w_left, w_right, w_enter;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_sync <= '0;
      r_dat_sync <= '0;
      r_clk_prev <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= w_clk_s;
    end
  end

  // Bits 0-7 data, 8 parity, 9 stop; the watchdog only runs mid-frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state <= RX_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'd0;
      r_parity   <= 1'b0;
      r_wd       <= '0;
      r_byte     <= 8'd0;
      r_byte_vld <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      r_rx_err   <= 1'b0;
      if (r_rx_state == RX_IDLE) begin
        r_wd <= '0;
        if (w_fall) begin
          if (!w_dat_s) begin
            r_rx_state <= RX_SHIFT;
            r_bit_cnt  <= 4'd0;
          end else begin
            r_rx_err <= 1'b1;
          end
        end
      end else if (w_fall) begin
        r_wd      <= '0;
        r_bit_cnt <= r_bit_cnt + 4'd1;
        if (r_bit_cnt < 4'd8) begin
          r_shift <= {w_dat_s, r_shift[7:1]};
        end else if (r_bit_cnt == 4'd8) begin
          r_parity <= w_dat_s;
        end else begin
          r_rx_state <= RX_IDLE;
          if ((^r_shift ^ r_parity) && w_dat_s) begin
            r_byte     <= r_shift;
            r_byte_vld <= 1'b1;
          end else begin
            r_rx_err <= 1'b1;
          end
        end
      end else if (r_wd == WD_LIMIT) begin
        r_rx_state <= RX_IDLE;
        r_rx_err   <= 1'b1;
      end else if (r_wd != {WD_W{1'b1}}) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  assign w_ext     = (r_dec_state == DEC_E0) || (r_dec_state == DEC_E0F0);
  assign w_brk     = (r_dec_state == DEC_F0) || (r_dec_state == DEC_E0F0);
  assign w_e0_step = (r_dec_state == DEC_BASE) && (r_byte == 8'hE0);
  assign w_f0_step = ((r_dec_state == DEC_BASE) || (r_dec_state == DEC_E0)) && (r_byte == 8'hF0);
  assign w_final   = r_byte_vld && !w_e0_step && !w_f0_step;

  always_comb begin
    w_num    = 4'd0;
    w_up     = 1'b0;
    w_down   = 1'b0;
    w_left   = 1'b0;
    w_right  = 1'b0;
    w_enter  = 1'b0;
    w_mapped = 1'b1;
    case ({w_ext, r_byte})
      9'h016:  w_num = 4'd1;
      9'h01E:  w_num = 4'd2;
      9'h026:  w_num = 4'd3;
      9'h025:  w_num = 4'd4;
      9'h02E:  w_num = 4'd5;
      9'h036:  w_num = 4'd6;
      9'h03D:  w_num = 4'd7;
      9'h03E:  w_num = 4'd8;
      9'h046:  w_num = 4'd9;
      9'h05A:  w_enter = 1'b1;
      9'h175:  w_up    = 1'b1;
      9'h172:  w_down  = 1'b1;
      9'h16B:  w_left  = 1'b1;
      9'h174:  w_right = 1'b1;
      default: w_mapped = 1'b0;
    endcase
  end

  assign w_held_match = r_held_vld && (r_held_ext == w_ext) && (r_held_code == r_byte);
  assign w_make       = w_final && !w_brk && w_mapped;
`ifdef PS2_TYPEMATIC_EN
  assign w_emit = w_make;
`else
  assign w_emit = w_make && !w_held_match;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dec_state <= DEC_BASE;
      r_held_code <= 8'd0;
      r_held_ext  <= 1'b0;
      r_held_vld  <= 1'b0;
      cmd_number  <= 4'd0;
      cmd_up      <= 1'b0;
      cmd_down    <= 1'b0;
      cmd_left    <= 1'b0;
      cmd_right   <= 1'b0;
      cmd_enter   <= 1'b0;
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (r_rx_err) begin
        r_dec_state <= DEC_BASE;
      end else if (r_byte_vld) begin
        if (w_e0_step)      r_dec_state <= DEC_E0;
        else if (w_f0_step) r_dec_state <= (r_dec_state == DEC_BASE) ? DEC_F0 : DEC_E0F0;
        else                r_dec_state <= DEC_BASE;
      end
      if (w_make) begin
        r_held_code <= r_byte;
        r_held_ext  <= w_ext;
        r_held_vld  <= 1'b1;
      end else if (w_final && w_brk && w_held_match) begin
        r_held_vld <= 1'b0;
      end
      cmd_valid   <= w_emit;
      cmd_number  <= w_emit ? w_num : 4'd0;
      cmd_up      <= w_emit & w_up;
      cmd_down    <= w_emit & w_down;
      cmd_left    <= w_emit & w_left;
      cmd_right   <= w_emit & w_right;
      cmd_enter   <= w_emit & w_enter;
      frame_error <= r_rx_err;
    end
  end

endmodule
